// File: rtl/bf_exec_pkg.sv
// Shared state encoding and Brainfuck opcode constants
// for the execution controller.
package bf_exec_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_SCAN_FWD,
    ST_SCAN_BACK,
    ST_OUT_WAIT,
    ST_IN_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LOOP  = 8'h5B;
  localparam logic [7:0] OP_END   = 8'h5D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_NUL   = 8'h00;

endpackage

// File: rtl/bf_exec_controller.sv
// Brainfuck execution controller: fetches from a combinational
// ROM and issues cell-memory and byte I/O commands.
module bf_exec_controller
  import bf_exec_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int DEPTH_W = 8
) (
  input  logic            working_clock,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  input  logic            mem_available,
  input  logic [7:0]      ptr_value,
  output logic [7:0]      ptr_new_value,
  output logic            ptr_set_value,
  output logic            ptr_move,
  output logic            ptr_move_dir,
  output logic            roll_back,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  output logic            error
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [DEPTH_W-1:0] r_depth;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic               r_rb_done;
  logic [7:0]         r_out_data;
  logic               w_out_load;

  logic            w_pc_last;
  logic            w_pc_zero;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_depth_max;
  logic            w_depth_one;
  logic            w_cell_zero;
  logic            w_lp;
  logic            w_end;
  state_t          w_adv;

  assign w_pc_last   = &r_pc;
  assign w_pc_zero   = (r_pc == '0);
  assign w_pc_inc    = r_pc + 1'b1;
  assign w_depth_max = &r_depth;
  assign w_depth_one = (r_depth == DEPTH_W'(1));
  assign w_cell_zero = (ptr_value == 8'h00);
  assign w_lp        = (prog_data == OP_LOOP);
  assign w_end       = (prog_data == OP_END);
  // Advancing past the last ROM address ends the program.
  assign w_adv       = w_pc_last ? ST_DONE : ST_RUN;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_depth_nxt   = r_depth;
    w_out_load    = 1'b0;
    ptr_new_value = 8'h00;
    ptr_set_value = 1'b0;
    ptr_move      = 1'b0;
    ptr_move_dir  = 1'b0;
    roll_back     = 1'b0;
    out_valid     = 1'b0;
    in_ready      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_depth_nxt = '0;
          w_state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        roll_back = !r_rb_done;
        if (r_rb_done && mem_available)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = w_adv;
        case (prog_data)
          OP_INC: begin
            ptr_set_value = 1'b1;
            ptr_new_value = ptr_value + 8'd1;
          end
          OP_DEC: begin
            ptr_set_value = 1'b1;
            ptr_new_value = ptr_value - 8'd1;
          end
          OP_RIGHT: begin
            ptr_move     = 1'b1;
            ptr_move_dir = 1'b1;
          end
          OP_LEFT: ptr_move = 1'b1;
          OP_OUT: begin
            w_out_load  = 1'b1;
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_OUT_WAIT;
          end
          OP_IN: begin
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_IN_WAIT;
          end
          OP_LOOP: begin
            if (w_cell_zero) begin
              w_depth_nxt = DEPTH_W'(1);
              w_state_nxt = w_pc_last ? ST_ERROR : ST_SCAN_FWD;
            end
          end
          OP_END: begin
            if (!w_cell_zero) begin
              w_depth_nxt = DEPTH_W'(1);
              w_pc_nxt    = r_pc - 1'b1;
              w_state_nxt = w_pc_zero ? ST_ERROR : ST_SCAN_BACK;
            end
          end
          OP_NUL: begin
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_DONE;
          end
          default: ;
        endcase
      end
      ST_SCAN_FWD: begin
        w_pc_nxt = w_pc_inc;
        if (prog_data == OP_NUL) begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_ERROR;
        end else if (w_lp && w_depth_max) begin
          w_state_nxt = ST_ERROR;
        end else if (w_end && w_depth_one) begin
          w_depth_nxt = '0;
          w_state_nxt = w_adv;
        end else if (w_pc_last) begin
          w_state_nxt = ST_ERROR;
        end else if (w_lp) begin
          w_depth_nxt = r_depth + 1'b1;
        end else if (w_end) begin
          w_depth_nxt = r_depth - 1'b1;
        end
      end
      ST_SCAN_BACK: begin
        if (w_end && w_depth_max) begin
          w_state_nxt = ST_ERROR;
        end else if (w_lp && w_depth_one) begin
          w_depth_nxt = '0;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_RUN;
        end else if (w_pc_zero) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_pc_nxt = r_pc - 1'b1;
          if (w_lp)  w_depth_nxt = r_depth - 1'b1;
          if (w_end) w_depth_nxt = r_depth + 1'b1;
        end
      end
      ST_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = w_adv;
        end
      end
      ST_IN_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ptr_set_value = 1'b1;
          ptr_new_value = in_data;
          w_pc_nxt      = w_pc_inc;
          w_state_nxt   = w_adv;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge working_clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_depth    <= '0;
      r_rb_done  <= 1'b0;
      r_out_data <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_depth   <= w_depth_nxt;
      r_rb_done <= (r_state == ST_INIT);
      if (w_out_load)
        r_out_data <= ptr_value;
    end
  end

  assign prog_addr = r_pc;
  assign out_data  = r_out_data;
  assign busy      = (r_state == ST_INIT)     ||
                     (r_state == ST_RUN)      ||
                     (r_state == ST_SCAN_FWD) ||
                     (r_state == ST_SCAN_BACK)||
                     (r_state == ST_OUT_WAIT) ||
                     (r_state == ST_IN_WAIT);
  assign done      = (r_state == ST_DONE);
  assign error     = (r_state == ST_ERROR);

endmodule

// File: tb/tb_bf_exec_controller.sv
// Bench for bf_exec_controller with a program ROM and an
// 8-cell memory model (saturating pointer, clears on roll_back).
module tb_bf_exec_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] prog_addr;
  logic [7:0] prog_data;
  logic       mem_available;
  logic [7:0] ptr_value;
  logic [7:0] ptr_new_value;
  logic       ptr_set_value;
  logic       ptr_move;
  logic       ptr_move_dir;
  logic       roll_back;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       error;

  bf_exec_controller #(.PC_W(10), .DEPTH_W(8)) dut (
    .working_clock (clk),
    .reset         (rst_n),
    .start         (start),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .mem_available (mem_available),
    .ptr_value     (ptr_value),
    .ptr_new_value (ptr_new_value),
    .ptr_set_value (ptr_set_value),
    .ptr_move      (ptr_move),
    .ptr_move_dir  (ptr_move_dir),
    .roll_back     (roll_back),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [0:1023];
  assign prog_data = rom[prog_addr];

  logic [7:0] cells [0:7];
  logic [2:0] ptr;
  int         avail_cnt;
  assign ptr_value = cells[ptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cells[i] <= 8'h00;
      ptr           <= 3'd0;
      mem_available <= 1'b1;
      avail_cnt     <= 0;
    end else if (roll_back) begin
      for (int i = 0; i < 8; i++) cells[i] <= 8'h00;
      ptr           <= 3'd0;
      mem_available <= 1'b0;
      avail_cnt     <= 3;
    end else begin
      if (avail_cnt != 0) begin
        avail_cnt <= avail_cnt - 1;
        if (avail_cnt == 1) mem_available <= 1'b1;
      end
      if (ptr_set_value) cells[ptr] <= ptr_new_value;
      if (ptr_move) begin
        if (ptr_move_dir && ptr != 3'd7) ptr <= ptr + 3'd1;
        if (!ptr_move_dir && ptr != 3'd0) ptr <= ptr - 3'd1;
      end
    end
  end

  int n_checks;
  int n_fail;
  int n_set;
  int n_move;
  int n_out;
  logic [7:0] last_out;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        last_out = out_data;
        n_out++;
      end
      if (ptr_set_value) n_set++;
      if (ptr_move) n_move++;
      chk("pulse_onehot",
          32'(ptr_set_value + ptr_move + roll_back) <= 32'd1, 32'd1);
    end
  end

  task automatic load_prog(input string s);
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s.getc(i);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    n_set = 0; n_move = 0; n_out = 0; last_out = 8'hXX;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!(done || error) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [7:0] in_b;
    logic       exp_done;
    logic       exp_err;
    int         exp_set;
    int         exp_move;
    int         exp_nout;
    logic [7:0] exp_out;
  } vec_t;

  string progs [12];
  vec_t  vecs  [12];

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    in_data = 8'h00; in_valid = 1'b0;
    n_checks = 0; n_fail = 0; n_set = 0; n_move = 0; n_out = 0;
    last_out = 8'h00;
    load_prog("");

    progs[0]  = "+++.";        vecs[0]  = '{8'h00, 1, 0, 3, 0, 1, 8'h03};
    progs[1]  = "-.";          vecs[1]  = '{8'h00, 1, 0, 1, 0, 1, 8'hFF};
    progs[2]  = "[+++].";      vecs[2]  = '{8'h00, 1, 0, 0, 0, 1, 8'h00};
    progs[3]  = "++[->+<]>.";  vecs[3]  = '{8'h00, 1, 0, 6, 5, 1, 8'h02};
    progs[4]  = "[";           vecs[4]  = '{8'h00, 0, 1, 0, 0, 0, 8'h00};
    progs[5]  = ",.";          vecs[5]  = '{8'h41, 1, 0, 1, 0, 1, 8'h41};
    progs[6]  = "a+b.";        vecs[6]  = '{8'h00, 1, 0, 1, 0, 1, 8'h01};
    progs[7]  = "+[-].";       vecs[7]  = '{8'h00, 1, 0, 2, 0, 1, 8'h00};
    progs[8]  = "+]";          vecs[8]  = '{8'h00, 0, 1, 1, 0, 0, 8'h00};
    progs[9]  = "[[]]+.";      vecs[9]  = '{8'h00, 1, 0, 1, 0, 1, 8'h01};
    progs[10] = "<<+.";        vecs[10] = '{8'h00, 1, 0, 1, 2, 1, 8'h01};
    progs[11] = ">>>>>>>>>+."; vecs[11] = '{8'h00, 1, 0, 1, 9, 1, 8'h01};

    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_pc", 32'(prog_addr), 32'd0);

    for (int v = 0; v < 12; v++) begin
      load_prog(progs[v]);
      in_data  = vecs[v].in_b;
      in_valid = 1'b1;
      pulse_start();
      wait_end($sformatf("v%0d", v));
      chk($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_err", v), 32'(error), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_sets", v), 32'(n_set), 32'(vecs[v].exp_set));
      chk($sformatf("v%0d_moves", v), 32'(n_move), 32'(vecs[v].exp_move));
      chk($sformatf("v%0d_nout", v), 32'(n_out), 32'(vecs[v].exp_nout));
      if (vecs[v].exp_nout != 0)
        chk($sformatf("v%0d_out", v), 32'(last_out), 32'(vecs[v].exp_out));
    end

    // Latency: first '+' cycle to DONE is six cycles.
    begin
      int k;
      load_prog("+++.");
      pulse_start();
      k = 0;
      @(negedge clk);
      while (!ptr_set_value && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("lat_first_set", 32'(ptr_set_value), 32'd1);
      repeat (5) @(negedge clk);
      chk("lat_done_c5", 32'(done), 32'd0);
      @(negedge clk);
      chk("lat_done_c6", 32'(done), 32'd1);
    end

    // Output stall holds valid, data and pc.
    begin
      int k;
      load_prog("++.");
      out_ready = 1'b0;
      pulse_start();
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      repeat (4) @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h02);
      chk("stall_pc", 32'(prog_addr), 32'd2);
      chk("stall_nout", 32'(n_out), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_end("stall");
      chk("stall_out", 32'(last_out), 32'h02);
      chk("stall_done", 32'(done), 32'd1);
    end

    // Input wait until in_valid.
    begin
      int k;
      load_prog(",.");
      in_valid = 1'b0;
      in_data  = 8'h7A;
      pulse_start();
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      repeat (3) @(negedge clk);
      chk("inw_ready", 32'(in_ready), 32'd1);
      chk("inw_nset", 32'(n_set), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      wait_end("inw");
      chk("inw_out", 32'(last_out), 32'h7A);
    end

    // Start while busy is ignored.
    load_prog("+++++.");
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_end("ign");
    chk("ign_out", 32'(last_out), 32'h05);
    chk("ign_sets", 32'(n_set), 32'd5);

    // Reset in the middle of a forward scan.
    begin
      int k;
      load_prog("[++++++++++++++++++++].");
      pulse_start();
      k = 0;
      @(negedge clk);
      while (prog_addr < 10'd5 && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("mid_scan_reached", 32'(prog_addr >= 10'd5), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs",
          32'({prog_addr, busy, done, error, out_valid, in_ready,
               ptr_set_value, ptr_move, roll_back}), 32'd0);
      chk("mid_rst_data", 32'({out_data, ptr_new_value}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulse_start();
      k = 0;
      while (!roll_back && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("re_rollback", 32'(roll_back), 32'd1);
      chk("re_pc", 32'(prog_addr), 32'd0);
      wait_end("re");
      chk("re_done", 32'(done), 32'd1);
      chk("re_out", 32'(last_out), 32'h00);
      chk("re_sets", 32'(n_set), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_exec_controller.md
BF_EXEC_CONTROLLER -- requirements
Module: bf_exec_controller

Interface
REQ-001 SHALL have parameter PC_W, default 10, program address width.
REQ-002 SHALL have parameter DEPTH_W, default 8, bracket-scan depth counter width.
REQ-003 SHALL have port working_clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins execution.
REQ-006 SHALL have port prog_addr  out  PC_W  program counter; program ROM returns prog_data combinationally.
REQ-007 SHALL have port prog_data  in  8  ASCII instruction at prog_addr; 8'h00 marks end of program.
REQ-008 SHALL have port mem_available  in  1  cell memory initialised and ready.
REQ-009 SHALL have port ptr_value  in  8  current cell value from cell memory.
REQ-010 SHALL have ports ptr_new_value  out  8, ptr_set_value  out  1, ptr_move  out  1, ptr_move_dir  out  1 (1 = right), roll_back  out  1  cell memory commands.
REQ-011 SHALL have ports out_data  out  8, out_valid  out  1, out_ready  in  1  output byte handshake.
REQ-012 SHALL have ports in_data  in  8, in_valid  in  1, in_ready  out  1  input byte handshake.
REQ-013 SHALL have ports busy  out  1, done  out  1, error  out  1  status.

Function
REQ-014 SHALL implement states IDLE, INIT, RUN, SCAN_FWD, SCAN_BACK, OUT_WAIT, IN_WAIT, DONE, ERROR.
REQ-015 IDLE: on start, pc <= 0 and go to INIT; start in any other state SHALL be ignored.
REQ-016 INIT: assert roll_back for exactly one cycle, then wait until mem_available=1, then RUN.
REQ-017 RUN: one instruction per cycle; '+'/'-' drive ptr_new_value = ptr_value +/- 1 mod 256 with ptr_set_value=1; '>'/'<' pulse ptr_move with dir 1/0; pc <= pc+1.
REQ-018 RUN: any byte other than + - < > [ ] . , and 8'h00 SHALL be skipped in one cycle with no memory command.
REQ-019 '[' with ptr_value!=0 or ']' with ptr_value==0: pc <= pc+1, one cycle.
REQ-020 '[' with ptr_value==0: depth <= 1, pc <= pc+1, go SCAN_FWD; per cycle '[' increments depth, ']' decrements; when ']' brings depth to 0, pc <= pc+1 and return to RUN.
REQ-021 ']' with ptr_value!=0: depth <= 1, pc <= pc-1, go SCAN_BACK; mirrored counting; on the matching '[' pc <= pc+1 and RUN.
REQ-022 SCAN_FWD reaching 8'h00 or pc all-ones, SCAN_BACK needing pc below 0, or depth overflow SHALL go to ERROR.
REQ-023 '.': out_data <= ptr_value, out_valid=1 in OUT_WAIT until out_ready; on handshake cycle pc <= pc+1, RUN.
REQ-024 ',': in_ready=1 in IN_WAIT; on in_valid, ptr_new_value=in_data with ptr_set_value=1 that cycle, pc <= pc+1, RUN.
REQ-025 8'h00 in RUN, or pc+1 overflowing PC_W, SHALL go to DONE.
REQ-026 At most one of ptr_set_value, ptr_move, roll_back SHALL be high in any cycle; all are one-cycle pulses.
REQ-027 '<' at cell 0 and '>' at last cell SHALL still pulse ptr_move; saturation belongs to cell memory.
REQ-028 busy=1 in INIT..IN_WAIT; done=1 held in DONE; error=1 held in ERROR; DONE/ERROR return to IDLE on start, re-entering INIT.

Reset
REQ-029 Reset low SHALL immediately force IDLE, pc=0, depth=0, all command pulses, out_valid, in_ready, busy, done, error, out_data, ptr_new_value to 0, including mid-scan or mid-handshake.

Structure
REQ-030 Shared package SHALL hold state encoding and ASCII opcode constants (8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C).
REQ-031 Single module; no sub-module needed; pc and depth counters inline.

Verification
REQ-032 "+++.\0": out_data=8'h03 on handshake; done after 6 cycles from RUN with out_ready=1.
REQ-033 "-.\0": out_data=8'hFF (wrap).
REQ-034 "[+++].\0" on zero cell: no ptr_set_value pulses; out_data=8'h00; done.
REQ-035 "++[->+<]>.\0": out_data=8'h02.
REQ-036 "[\0" on zero cell -> error=1; ",.\0" with in_data=8'h41 -> out_data=8'h41.
REQ-037 Reset low during SCAN_FWD -> all outputs 0 same cycle; next start restarts at pc=0 with roll_back pulse.
